// File: rtl/frame_stats_monitor.sv
// Per-frame pixel statistics and stream-timing checker for a 2-pixel-per-clock RGB888 stream.
// Results are published once per completed frame; a protocol error flag stays set until the next clean frame start.
module frame_stats_monitor #(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int BRIGHT_SUM = 270
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        VSYNC,
  input  logic        HSYNC,
  input  logic [7:0]  DATA_R0,
  input  logic [7:0]  DATA_G0,
  input  logic [7:0]  DATA_B0,
  input  logic [7:0]  DATA_R1,
  input  logic [7:0]  DATA_G1,
  input  logic [7:0]  DATA_B1,
  output logic        stats_valid,
  output logic [15:0] frame_count,
  output logic [31:0] pixel_sum,
  output logic [9:0]  sum_min,
  output logic [9:0]  sum_max,
  output logic [19:0] bright_count,
  output logic        line_err,
  output logic        frame_err
);

  localparam int LW = $clog2(HEIGHT + 1);
  localparam logic [9:0]    PAIRS     = 10'(WIDTH / 2);
  localparam logic [LW-1:0] LAST_LINE = LW'(HEIGHT - 1);
  localparam logic [10:0]   BRIGHT    = 11'(BRIGHT_SUM);

  typedef enum logic [2:0] {IDLE, ARMED, LINE, GAP, FLUSH, PUBLISH} state_t;

  state_t        state;
  logic          v_prev, h_prev;
  logic          v_rise, h_rise;
  logic          accept, acc_clear;
  logic [9:0]    s0, s1;
  logic          v1;
  logic [31:0]   acc_sum;
  logic [9:0]    acc_min, acc_max;
  logic [19:0]   acc_bright;
  logic [9:0]    pair_cnt;
  logic [LW-1:0] line_cnt;
  logic          line_err_acc;
  logic [9:0]    pair_min, pair_max;

  assign v_rise = VSYNC & ~v_prev;
  assign h_rise = HSYNC & ~h_prev;

  // Which pixel pairs belong to the frame, and when the frame's accumulators restart.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    accept    = 1'b0;
    acc_clear = 1'b0;
    case (state)
      IDLE:  acc_clear = v_rise;
      ARMED: accept    = h_rise & ~VSYNC;
      LINE:  accept    = HSYNC;
      GAP: begin
        acc_clear = v_rise;
        accept    = h_rise & ~v_rise;
      end
      default: ;
    endcase
  end

  // Stage 1: per-pixel channel sums plus the accepted-pair flag.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      s0     <= '0;
      s1     <= '0;
      v1     <= 1'b0;
      v_prev <= 1'b0;
      h_prev <= 1'b0;
    end else begin
      s0     <= 10'(DATA_R0) + 10'(DATA_G0) + 10'(DATA_B0);
      s1     <= 10'(DATA_R1) + 10'(DATA_G1) + 10'(DATA_B1);
      v1     <= accept;
      v_prev <= VSYNC;
      h_prev <= HSYNC;
    end
  end

  assign pair_min = (s0 < s1) ? s0 : s1;
  assign pair_max = (s0 > s1) ? s0 : s1;

  // Stage 2: frame accumulators; a frame-start clear wins over a pending accumulate.
  always_ff @(posedge HCLK) begin
    if (HRESET || acc_clear) begin
      acc_sum    <= '0;
      acc_min    <= 10'h3FF;
      acc_max    <= '0;
      acc_bright <= '0;
    end else if (v1) begin
      acc_sum    <= acc_sum + 32'(s0) + 32'(s1);
      acc_min    <= (pair_min < acc_min) ? pair_min : acc_min;
      acc_max    <= (pair_max > acc_max) ? pair_max : acc_max;
      acc_bright <= acc_bright + 20'({1'b0, s0} > BRIGHT) + 20'({1'b0, s1} > BRIGHT);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state        <= IDLE;
      pair_cnt     <= '0;
      line_cnt     <= '0;
      line_err_acc <= 1'b0;
      stats_valid  <= 1'b0;
      frame_count  <= '0;
      pixel_sum    <= '0;
      sum_min      <= '0;
      sum_max      <= '0;
      bright_count <= '0;
      line_err     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (v_rise) begin
            frame_err    <= 1'b0;
            line_err_acc <= 1'b0;
            line_cnt     <= '0;
            pair_cnt     <= '0;
            state        <= ARMED;
          end else if (HSYNC) begin
            frame_err <= 1'b1;
          end
        end
        ARMED: begin
          if (HSYNC && VSYNC) begin
            frame_err <= 1'b1;
          end else if (h_rise) begin
            pair_cnt <= 10'd1;
            state    <= LINE;
          end
        end
        LINE: begin
          if (HSYNC) begin
            if (pair_cnt != 10'h3FF) pair_cnt <= pair_cnt + 10'd1;
          end else begin
            if (pair_cnt != PAIRS) line_err_acc <= 1'b1;
            pair_cnt <= '0;
            line_cnt <= line_cnt + LW'(1);
            state    <= (line_cnt == LAST_LINE) ? FLUSH : GAP;
          end
        end
        GAP: begin
          if (v_rise) begin
            // Frame aborted mid-way: restart cleanly and publish nothing for it.
            frame_err    <= 1'b1;
            line_err_acc <= 1'b0;
            line_cnt     <= '0;
            pair_cnt     <= '0;
            state        <= ARMED;
          end else if (h_rise) begin
            pair_cnt <= 10'd1;
            state    <= LINE;
          end
        end
        FLUSH: state <= PUBLISH;
        PUBLISH: begin
          pixel_sum    <= acc_sum;
          sum_min      <= acc_min;
          sum_max      <= acc_max;
          bright_count <= acc_bright;
          line_err     <= line_err_acc;
          frame_count  <= frame_count + 16'd1;
          stats_valid  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_stats_monitor.sv
// Scoreboard bench: frame expectations are modelled while stimulus is driven and popped on stats_valid.
module tb_frame_stats_monitor;

  localparam int BRIGHT = 270;

  logic       HCLK = 1'b0;
  logic       HRESET, VSYNC, HSYNC;
  logic [7:0] DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;

  logic        a_valid, b_valid;
  logic [15:0] a_fc, b_fc;
  logic [31:0] a_sum, b_sum;
  logic [9:0]  a_min, b_min, a_max, b_max;
  logic [19:0] a_br, b_br;
  logic        a_le, b_le, a_fe, b_fe;

  always #5 HCLK = ~HCLK;

  frame_stats_monitor #(.WIDTH(8), .HEIGHT(4), .BRIGHT_SUM(BRIGHT)) dut_small (
    .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .stats_valid(a_valid), .frame_count(a_fc), .pixel_sum(a_sum),
    .sum_min(a_min), .sum_max(a_max), .bright_count(a_br),
    .line_err(a_le), .frame_err(a_fe)
  );

  frame_stats_monitor #(.WIDTH(256), .HEIGHT(64), .BRIGHT_SUM(BRIGHT)) dut_large (
    .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .stats_valid(b_valid), .frame_count(b_fc), .pixel_sum(b_sum),
    .sum_min(b_min), .sum_max(b_max), .bright_count(b_br),
    .line_err(b_le), .frame_err(b_fe)
  );

  bit mon_sel = 1'b0;
  logic        m_valid, m_le, m_fe;
  logic [15:0] m_fc;
  logic [31:0] m_sum;
  logic [9:0]  m_min, m_max;
  logic [19:0] m_br;
  assign m_valid = mon_sel ? b_valid : a_valid;
  assign m_fc    = mon_sel ? b_fc    : a_fc;
  assign m_sum   = mon_sel ? b_sum   : a_sum;
  assign m_min   = mon_sel ? b_min   : a_min;
  assign m_max   = mon_sel ? b_max   : a_max;
  assign m_br    = mon_sel ? b_br    : a_br;
  assign m_le    = mon_sel ? b_le    : a_le;
  assign m_fe    = mon_sel ? b_fe    : a_fe;

  typedef struct {
    int unsigned cyc;
    int unsigned fc;
    int unsigned sum;
    int unsigned mn;
    int unsigned mx;
    int unsigned br;
    int unsigned le;
    bit          chk_fe;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          cur_w = 8;
  int          cur_h = 4;
  int          mode = 0;
  int unsigned md_sum, md_min, md_max, md_br, md_le, md_fc, last_cyc;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int l, input int x);
    case (mode)
      1: begin
        if (l == 1 && x == 0) return {8'd255, 8'd255, 8'd255};
        if (l == 2 && x == cur_w - 1) return {8'd0, 8'd0, 8'd0};
        return {8'd10, 8'd10, 8'd10};
      end
      2: begin
        if (x == 0) return {8'd90, 8'd90, 8'd90};
        if (x == 1) return {8'd90, 8'd90, 8'd91};
        if (x == 2) return {8'd255, 8'd0, 8'd16};
        return {8'd10, 8'd10, 8'd10};
      end
      3: return {8'd50, 8'd50, 8'd50};
      default: return {8'd10, 8'd10, 8'd10};
    endcase
  endfunction

  function automatic int unsigned csum(input logic [23:0] p);
    return int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
  endfunction

  task automatic model_pixel(input int unsigned s);
    md_sum += s;
    if (s < md_min) md_min = s;
    if (s > md_max) md_max = s;
    if (s > BRIGHT) md_br++;
  endtask

  task automatic model_reset();
    md_sum = 0; md_min = 1023; md_max = 0; md_br = 0; md_le = 0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge HCLK);
  endtask

  task automatic drive_line(input int l, input int npairs);
    logic [23:0] p0, p1;
    for (int p = 0; p < npairs; p++) begin
      p0 = pix(l, 2 * p);
      p1 = pix(l, 2 * p + 1);
      @(posedge HCLK); #1;
      HSYNC = 1'b1;
      {DATA_R0, DATA_G0, DATA_B0} = p0;
      {DATA_R1, DATA_G1, DATA_B1} = p1;
      model_pixel(csum(p0));
      model_pixel(csum(p1));
      last_cyc = cyc;
    end
    @(posedge HCLK); #1;
    HSYNC = 1'b0;
    if (npairs != cur_w / 2) md_le = 1;
  endtask

  task automatic drive_vsync();
    @(posedge HCLK); #1;
    VSYNC = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 VSYNC = 1'b0;
    model_reset();
  endtask

  task automatic run_lines(input int first, input int bad_line, input int bad_len);
    for (int l = first; l < cur_h; l++) begin
      gap(4);
      drive_line(l, (l == bad_line) ? bad_len : cur_w / 2);
    end
  endtask

  task automatic push_exp(input bit chk_fe);
    exp_t e;
    md_fc++;
    e.cyc = last_cyc + 4; e.fc = md_fc; e.sum = md_sum; e.mn = md_min;
    e.mx = md_max; e.br = md_br; e.le = md_le; e.chk_fe = chk_fe;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge HCLK);
    check("drain", 32'(sb.size()), 0);
    gap(2);
  endtask

  task automatic frame(input int m, input int bad_line, input int bad_len);
    mode = m;
    drive_vsync();
    @(negedge HCLK);
    check("ferr_clear", 32'(m_fe), 0);
    run_lines(0, bad_line, bad_len);
    push_exp(1'b1);
    drain();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 0);
    check({tag, "_fc"},    32'(m_fc), 0);
    check({tag, "_sum"},   m_sum, 0);
    check({tag, "_min"},   32'(m_min), 0);
    check({tag, "_max"},   32'(m_max), 0);
    check({tag, "_br"},    32'(m_br), 0);
    check({tag, "_le"},    32'(m_le), 0);
    check({tag, "_fe"},    32'(m_fe), 0);
  endtask

  always @(negedge HCLK) begin
    if (m_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(m_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        check("latency",      cyc, mon_e.cyc);
        check("frame_count",  32'(m_fc), mon_e.fc);
        check("pixel_sum",    m_sum, mon_e.sum);
        check("sum_min",      32'(m_min), mon_e.mn);
        check("sum_max",      32'(m_max), mon_e.mx);
        check("bright_count", 32'(m_br), mon_e.br);
        check("line_err",     32'(m_le), mon_e.le);
        if (mon_e.chk_fe) check("frame_err", 32'(m_fe), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; VSYNC = 1'b0; HSYNC = 1'b0;
    {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1} = '0;
    md_fc = 0; last_cyc = 0;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    check_zero("reset");

    // Flat image, then hot and cold pixels, then a short line followed by a clean frame.
    frame(0, -1, 0);
    frame(1, -1, 0);
    frame(0, 1, 3);
    frame(0, -1, 0);
    // Brightness threshold: a sum of exactly 270 is not bright, 271 is.
    frame(2, -1, 0);

    // Frame aborted by a VSYNC rise after two lines; the following lines form a full frame.
    mode = 0;
    drive_vsync();
    run_lines(cur_h - 2, -1, 0);
    gap(4);
    drive_vsync();
    @(negedge HCLK);
    check("abort_ferr", 32'(m_fe), 1);
    run_lines(0, -1, 0);
    push_exp(1'b0);
    drain();
    frame(0, -1, 0);

    // Reset pulse in the middle of the second line; the rest of that frame must publish nothing.
    drive_vsync();
    gap(4);
    drive_line(0, cur_w / 2);
    gap(4);
    for (int p = 0; p < 2; p++) begin
      @(posedge HCLK); #1 HSYNC = 1'b1;
    end
    @(posedge HCLK); #1 HRESET = 1'b1;
    @(posedge HCLK); #1 HRESET = 1'b0;
    @(negedge HCLK);
    check_zero("midrst");
    md_fc = 0;
    @(posedge HCLK); #1 HSYNC = 1'b0;
    run_lines(2, -1, 0);
    gap(20);
    frame(0, -1, 0);

    // Larger image with a constant 50-valued picture on the second instance.
    mon_sel = 1'b1;
    cur_w = 256;
    cur_h = 64;
    @(posedge HCLK); #1 HRESET = 1'b1;
    @(posedge HCLK); #1 HRESET = 1'b0;
    md_fc = 0;
    frame(3, -1, 0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_stats_monitor.md
Name: frame_stats_monitor

Overview:
- Sits directly downstream of the image processing stage and consumes its 2-pixel-per-clock RGB888 stream, qualified by HSYNC and framed by VSYNC.
- Per frame, accumulates pixel statistics: channel-sum min, max and total, plus a count of bright pixels.
- Checks stream timing and reports line and frame protocol errors.
- Publishes one registered result set per frame for on-chip readout and for self-checking benches.

Parameters:
- WIDTH, 768, pixels per line (even).
- HEIGHT, 512, lines per frame.
- BRIGHT_SUM, 270, a pixel is "bright" when R+G+B > BRIGHT_SUM.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- VSYNC  in  1  high during frame startup period; rising edge marks frame start.
- HSYNC  in  1  high = DATA_* carry a valid pixel pair this cycle.
- DATA_R0, DATA_G0, DATA_B0  in  8 each  even pixel.
- DATA_R1, DATA_G1, DATA_B1  in  8 each  odd pixel.
- stats_valid  out  1  one-cycle pulse; result outputs are updated.
- frame_count  out  16  completed frames; wraps at 65535 -> 0.
- pixel_sum  out  32  sum of R+G+B over the frame.
- sum_min  out  10  minimum per-pixel R+G+B.
- sum_max  out  10  maximum per-pixel R+G+B.
- bright_count  out  20  pixels with R+G+B > BRIGHT_SUM.
- line_err  out  1  a line of the published frame had run length != WIDTH/2.
- frame_err  out  1  sticky protocol error; cleared at next valid frame start.

Behaviour:
- Reset: every output 0; FSM enters IDLE; all accumulators and counters cleared.
- Stage 1 (registered): s0 = R0+G0+B0 and s1 = R1+G1+B1, each 10 bits. Also registers a valid bit equal to the HSYNC-qualified sample.
- Stage 2 (accumulator, on valid):
  - acc_sum += s0+s1.
  - acc_min = min(acc_min, s0, s1), with acc_min initialised to 1023.
  - acc_max = max(acc_max, s0, s1), with acc_max initialised to 0.
  - acc_bright += (s0>BRIGHT_SUM) + (s1>BRIGHT_SUM).
- Edge detection: VSYNC and HSYNC are delayed by one register. Rise = cur & ~prev; fall = ~cur & prev.
- FSM states:
  - IDLE: a VSYNC rise clears the accumulators, clears frame_err, and moves to ARMED.
  - ARMED: waits for HSYNC rise, then LINE. If HSYNC is high while VSYNC is high, set frame_err and ignore the pair.
  - LINE: increments a pair counter (saturates at 1023) on each HSYNC-high cycle. On HSYNC fall:
    - if pair counter != WIDTH/2, set line_err_acc;
    - line counter +1, pair counter -> 0;
    - if the line counter reaches HEIGHT go to FLUSH, else GAP.
  - GAP: HSYNC rise -> LINE. VSYNC rise -> set frame_err, clear accumulators and line count, go to ARMED; no stats are published for the aborted frame.
  - FLUSH: waits 1 cycle for the stage-2 accumulate of the last pair, then PUBLISH.
  - PUBLISH: for one cycle:
    - copy acc_* to the outputs and line_err_acc to line_err;
    - frame_count +1;
    - stats_valid = 1;
    - go to IDLE.
- Latency: stats_valid is high exactly 3 cycles after the edge that samples the last valid pair of line HEIGHT.
- Output results hold until the next PUBLISH or reset.
- A pixel pair with HSYNC high in IDLE sets frame_err and is not accumulated.
- A VSYNC rise in IDLE takes precedence over a simultaneous HSYNC sample.
- Arithmetic: pixel_sum max is WIDTH*HEIGHT*765, which fits 32 bits for defaults. The accumulator must not wrap for the defaults; it wraps modulo 2^32 otherwise.
- HRESET asserted mid-frame: everything returns to reset values next edge; no stats_valid is produced.

Test Plan:
- WIDTH=8, HEIGHT=4, all pixels R=G=B=10, 4 HSYNC runs of 4 cycles separated by 5-cycle gaps:
  - stats_valid pulses once, 3 cycles after the last pair;
  - pixel_sum=960, sum_min=sum_max=30, bright_count=0, frame_count=1, line_err=0, frame_err=0.
- Same frame, but pixel 0 of line 2 = (255,255,255) and pixel 7 of line 3 = (0,0,0):
  - sum_max=765, sum_min=0, bright_count=1, pixel_sum=960-30+765-30=1665.
- Line 1 HSYNC run of 3 cycles instead of 4: line_err=1 in that frame's result. A following clean frame publishes line_err=0 and frame_count=2.
- VSYNC rise after 2 lines, then a full clean frame:
  - frame_err=1 after the abort;
  - exactly one stats_valid follows, with clean-frame values;
  - frame_err cleared at that second VSYNC rise... then remains 0.
- HRESET high for 1 cycle mid-line 2: all outputs 0 next cycle; no stats_valid until a new VSYNC-framed frame completes.
- Default parameters driven from the processing stage with a constant 50-valued image: pixel_sum=393216*150=58982400, bright_count=0, stats_valid once.
